core_ctrl_fsm: RTL and testbench
================================

Name: core_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the single-issue RV32 datapath.
- Fetches via an imem request/ready handshake and latches the instruction word through `ir_en`.
- Decodes opcode, funct3 and funct7, then drives the datapath controls: `pc_sel`, `reg_wen`, `alu_src`, `alu_op`, `mem_wen`, `mem_ren`, `wb_sel`.
- Holds the PC through `pc_en` until the instruction retires. Stalls on data-memory wait states, traps on illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles a single imem/dmem request may wait for ready before the block traps (valid range 2..255).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction word (IR output when `ir_en` is low; raw imem_rdata during fetch)
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid this cycle
- dmem_req  out  1  data memory request
- dmem_ready  in  1  data access completes this cycle
- ir_en  out  1  load instruction register
- pc_en  out  1  PC register update enable
- pc_sel  out  1  0 = PC+4, 1 = ALU result (JALR)
- reg_wen  out  1  register file write
- alu_src  out  1  0 = rs2, 1 = I-immediate
- alu_op  out  3  ALU operation (ctrl_pkg encoding)
- mem_wen  out  1  store
- mem_ren  out  1  load
- wb_sel  out  2  0 = ALU, 1 = dmem, 2 = PC+4
- trap  out  1  sticky fault flag
- trap_cause  out  2  0 = none, 1 = illegal, 2 = imem timeout, 3 = dmem timeout
- instret  out  CNT_W  retired-instruction count

Behaviour:
- **Reset:** asynchronous on rst_n low.
  - state = FETCH, wait counter = 0, instret = 0, trap = 0, trap_cause = 0.
  - All strobes are 0; alu_op = ADD, wb_sel = 0.
  - Reset mid-access drops the request immediately; no retirement is counted.
- **Outputs:** all control outputs are combinational from state and decoded IR; `instret` and `trap` are registered.
- **FETCH:**
  - `imem_req` = 1.
  - On `imem_ready`: `ir_en` = 1, go to EXEC.
  - Otherwise increment the wait counter; when it reaches MEM_TIMEOUT, go to TRAP with cause 2.
  - The counter clears on every state change.
- **EXEC** (one cycle), decode by opcode:
  - 0110011 R-type: `alu_src` = 0, `alu_op` from funct3/funct7[5]; `reg_wen`, `pc_en`, retire, go to FETCH.
  - 0010011 I-ALU: as R-type but `alu_src` = 1. funct7[5] is honoured only for SRAI; SRAI maps to SRL (no arithmetic shift; documented limitation).
  - 1100111 JALR: `alu_src` = 1, ADD, `pc_sel` = 1, `wb_sel` = 2, `reg_wen`, `pc_en`, retire, go to FETCH.
  - 0000011 LW, 0100011 SW: `alu_src` = 1, ADD, go to MEM.
  - Any other opcode, or funct3 other than 010 for loads and stores: go to TRAP with cause 1; no strobes.
- **MEM:**
  - `dmem_req` = 1; `mem_ren` (load) or `mem_wen` (store) held steady, with address controls held as in EXEC.
  - On `dmem_ready`: a load drives `wb_sel` = 1 and `reg_wen` = 1 in that same cycle. Both loads and stores assert `pc_en`, retire, and go to FETCH.
  - Timeout at MEM_TIMEOUT cycles: go to TRAP with cause 3; no `reg_wen` and no `pc_en`.
- **rd = x0:** `reg_wen` is forced to 0 whenever `instr[11:7]` = 0, including for JALR and LW.
- **TRAP:** absorbing state until reset. `trap` = 1, `trap_cause` is stable, and all request and write strobes stay 0.
- **Retire:** `instret` increments by exactly 1 on each retire cycle and wraps at 2^CNT_W − 1 → 0.
- **Simultaneous events:** ready arriving on the same cycle the counter reaches MEM_TIMEOUT counts as success; ready wins.
- **CPI:**
  - ALU/JALR: 2 cycles + fetch wait.
  - Load/store: 3 cycles + waits.

Decomposition:
- **ctrl_pkg** holds:
  - State enum: FETCH, EXEC, MEM, TRAP.
  - Opcode constants.
  - ALU op encoding: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLL 6, SRL 7.
  - wb_sel constants.
  - trap_cause constants.
  - Shared with the `alu` module and the datapath.
- **ctrl_decode:** one combinational sub-module, instr → alu_op / alu_src / wb_sel / op class / illegal. The FSM, wait counter and instret live in the top.

Test Plan:
- **ADD x3,x1,x2, imem_ready on first cycle:**
  - Cycle 0: FETCH, `imem_req` = 1, `ir_en` = 1.
  - Cycle 1: EXEC, `alu_op` = 0, `alu_src` = 0, `reg_wen` = 1, `pc_en` = 1.
  - `instret` = 1.
- **LW x5,8(x1), dmem_ready after 3 wait cycles:**
  - MEM lasts 4 cycles with `mem_ren` = 1 and `dmem_req` = 1.
  - Only the final cycle has `reg_wen` = 1, `wb_sel` = 1, `pc_en` = 1.
- **SW then JALR x1,0(x6):**
  - SW: `mem_wen` is held high until ready, and `reg_wen` = 0 throughout.
  - JALR: `pc_sel` = 1, `wb_sel` = 2, `reg_wen` = 1.
  - `instret` = 2.
- **Opcode 0x7F (illegal):**
  - EXEC is followed by `trap` = 1 with `trap_cause` = 1.
  - 20 further cycles: `imem_req` = 0 and `instret` is unchanged.
  - `rst_n` pulse clears to FETCH.
- **Timeout, MEM_TIMEOUT = 4, dmem_ready never asserts:**
  - After 4 MEM cycles, `trap_cause` = 3 and `reg_wen` was never asserted.
  - Repeat with ready on exactly the 4th cycle: must retire normally.
- **Corner cases:**
  - ADDI x0,x0,5: `reg_wen` = 0, `pc_en` = 1.
  - Asserting `rst_n` low mid-MEM: outputs drop asynchronously, before the next clk edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the RV32 multi-cycle control sequencer: FSM states,
// opcode constants, ALU/writeback/trap encodings and the funct3 -> ALU op map.
package ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        TRAP  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_JALR    = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_ILLEGAL = 3'd4
    } op_class_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_WORD = 3'b010;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_SRL = 3'd7;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

    // funct3 -> ALU op. SLTU shares SLT and SRA shares SRL: the ALU has no
    // unsigned compare or arithmetic shift. 'sub' only matters for ADD/SUB.
    function automatic logic [2:0] alu_op_from_f3(input logic [2:0] f3,
                                                  input logic       sub);
        logic [2:0] op;
        case (f3)
            3'b000:  op = sub ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/core_ctrl_fsm_decode.sv
// Pure combinational instruction decode: classifies the instruction and
// derives the ALU operation, operand select and writeback source.
module core_ctrl_fsm_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [2:0]  alu_op,
    output logic        alu_src,
    output logic [1:0]  wb_sel,
    output op_class_t   op_class,
    output logic        illegal,
    output logic        rd_zero
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7_b5   = instr[30];
    assign rd_zero     = (instr[11:7] == 5'd0);
    assign unused_bits = ^{instr[31], instr[29:15]};

    // Opcode/funct3 decode; anything unrecognised defaults to illegal.
    always_comb begin
        alu_op   = ALU_ADD;
        alu_src  = 1'b0;
        wb_sel   = WB_ALU;
        op_class = CLS_ILLEGAL;
        illegal  = 1'b1;
        case (opcode)
            OPC_OP: begin
                op_class = CLS_ALU;
                illegal  = 1'b0;
                alu_op   = alu_op_from_f3(funct3, funct7_b5);
            end
            OPC_OP_IMM: begin
                // funct7[5] only distinguishes SRAI, which maps to SRL anyway.
                op_class = CLS_ALU;
                illegal  = 1'b0;
                alu_src  = 1'b1;
                alu_op   = alu_op_from_f3(funct3, 1'b0);
            end
            OPC_JALR: begin
                op_class = CLS_JALR;
                illegal  = 1'b0;
                alu_src  = 1'b1;
                wb_sel   = WB_PC4;
            end
            OPC_LOAD: begin
                if (funct3 == F3_WORD) begin
                    op_class = CLS_LOAD;
                    illegal  = 1'b0;
                    alu_src  = 1'b1;
                    wb_sel   = WB_MEM;
                end
            end
            OPC_STORE: begin
                if (funct3 == F3_WORD) begin
                    op_class = CLS_STORE;
                    illegal  = 1'b0;
                    alu_src  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer for the single-issue RV32 datapath:
// FETCH -> EXEC -> (MEM) -> FETCH, with a sticky TRAP state on faults.
//
// Handshake: imem_req/dmem_req are held high for as long as the FSM sits in
// FETCH/MEM; a transfer completes on the rising edge where the matching
// *_ready is high. A request that waits MEM_TIMEOUT cycles traps instead,
// unless ready arrives on that final cycle, in which case ready wins.
module core_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    input  logic             dmem_ready,
    output logic             ir_en,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             reg_wen,
    output logic             alu_src,
    output logic [2:0]       alu_op,
    output logic             mem_wen,
    output logic             mem_ren,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             trap_q, trap_d;
    logic [1:0]       trap_cause_q, trap_cause_d;

    logic [2:0]  dec_alu_op;
    logic        dec_alu_src;
    logic [1:0]  dec_wb_sel;
    op_class_t   dec_class;
    logic        dec_illegal;
    logic        dec_rd_zero;
    logic [7:0]  wait_inc;
    logic        retire;

    core_ctrl_fsm_decode u_decode (
        .instr    (instr),
        .alu_op   (dec_alu_op),
        .alu_src  (dec_alu_src),
        .wb_sel   (dec_wb_sel),
        .op_class (dec_class),
        .illegal  (dec_illegal),
        .rd_zero  (dec_rd_zero)
    );

    assign wait_inc = wait_cnt_q + 8'd1;

    // Next-state, wait counter and all datapath controls.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        trap_d       = trap_q;
        trap_cause_d = trap_cause_q;
        retire       = 1'b0;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        ir_en        = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = 1'b0;
        reg_wen      = 1'b0;
        alu_src      = 1'b0;
        alu_op       = ALU_ADD;
        mem_wen      = 1'b0;
        mem_ren      = 1'b0;
        wb_sel       = WB_ALU;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_en      = 1'b1;
                    state_d    = EXEC;
                    wait_cnt_d = 8'd0;
                end else if (wait_inc >= TIMEOUT) begin
                    state_d      = TRAP;
                    wait_cnt_d   = 8'd0;
                    trap_d       = 1'b1;
                    trap_cause_d = CAUSE_IMEM_TO;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            EXEC: begin
                if (dec_illegal) begin
                    state_d      = TRAP;
                    trap_d       = 1'b1;
                    trap_cause_d = CAUSE_ILLEGAL;
                end else begin
                    alu_src = dec_alu_src;
                    alu_op  = dec_alu_op;
                    case (dec_class)
                        CLS_ALU, CLS_JALR: begin
                            pc_sel  = (dec_class == CLS_JALR);
                            wb_sel  = dec_wb_sel;
                            reg_wen = ~dec_rd_zero;
                            pc_en   = 1'b1;
                            retire  = 1'b1;
                            state_d = FETCH;
                        end
                        default: begin
                            // Loads/stores: address is formed now, wb waits for MEM.
                            wb_sel  = WB_ALU;
                            state_d = MEM;
                        end
                    endcase
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                alu_src  = 1'b1;
                alu_op   = ALU_ADD;
                mem_ren  = (dec_class == CLS_LOAD);
                mem_wen  = (dec_class == CLS_STORE);
                if (dmem_ready) begin
                    if (dec_class == CLS_LOAD) begin
                        wb_sel  = WB_MEM;
                        reg_wen = ~dec_rd_zero;
                    end
                    pc_en      = 1'b1;
                    retire     = 1'b1;
                    state_d    = FETCH;
                    wait_cnt_d = 8'd0;
                end else if (wait_inc >= TIMEOUT) begin
                    state_d      = TRAP;
                    wait_cnt_d   = 8'd0;
                    trap_d       = 1'b1;
                    trap_cause_d = CAUSE_DMEM_TO;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            default: ; // TRAP: absorbing, every strobe stays low
        endcase
        // While reset is held, strobes drop immediately, not at the next edge.
        if (!rst_n) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            ir_en    = 1'b0;
            pc_en    = 1'b0;
            pc_sel   = 1'b0;
            reg_wen  = 1'b0;
            alu_src  = 1'b0;
            alu_op   = ALU_ADD;
            mem_wen  = 1'b0;
            mem_ren  = 1'b0;
            wb_sel   = WB_ALU;
            retire   = 1'b0;
        end
        instret_d = retire ? instret_q + {{(CNT_W-1){1'b0}}, 1'b1} : instret_q;
    end

    // State, wait counter, retire counter and sticky trap registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            wait_cnt_q   <= 8'd0;
            instret_q    <= '0;
            trap_q       <= 1'b0;
            trap_cause_q <= CAUSE_NONE;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            instret_q    <= instret_d;
            trap_q       <= trap_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    assign trap       = trap_q;
    assign trap_cause = trap_cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed bench for core_ctrl_fsm with MEM_TIMEOUT = 4 and a 4-bit
// retire counter so the wrap-around is reachable.
module tb_core_ctrl_fsm;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      instr;
    logic             imem_req, imem_ready;
    logic             dmem_req, dmem_ready;
    logic             ir_en, pc_en, pc_sel, reg_wen, alu_src;
    logic [2:0]       alu_op;
    logic             mem_wen, mem_ren;
    logic [1:0]       wb_sel;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instret;

    int checks = 0;
    int errors = 0;

    core_ctrl_fsm #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .dmem_req   (dmem_req),
        .dmem_ready (dmem_ready),
        .ir_en      (ir_en),
        .pc_en      (pc_en),
        .pc_sel     (pc_sel),
        .reg_wen    (reg_wen),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .wb_sel     (wb_sel),
        .trap       (trap),
        .trap_cause (trap_cause),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch with 'waits' idle cycles before imem_ready; ends one tick into EXEC.
    task automatic fetch(input logic [31:0] w, input int waits);
        instr      = w;
        imem_ready = 1'b0;
        repeat (waits) begin
            #1;
            check("fetch_wait_req", 32'(imem_req), 32'd1);
            check("fetch_wait_ir_en", 32'(ir_en), 32'd0);
            tick();
        end
        imem_ready = 1'b1;
        #1;
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_ir_en", 32'(ir_en), 32'd1);
        tick();
        imem_ready = 1'b0;
    endtask

    task automatic exec_chk(input logic [2:0] op, input logic src, input logic rw,
                            input logic pe, input logic ps, input logic [1:0] wb);
        #1;
        check("exec_alu_op", 32'(alu_op), 32'(op));
        check("exec_alu_src", 32'(alu_src), 32'(src));
        check("exec_reg_wen", 32'(reg_wen), 32'(rw));
        check("exec_pc_en", 32'(pc_en), 32'(pe));
        check("exec_pc_sel", 32'(pc_sel), 32'(ps));
        check("exec_wb_sel", 32'(wb_sel), 32'(wb));
        check("exec_imem_req", 32'(imem_req), 32'd0);
        tick();
    endtask

    // MEM phase: 'waits' cycles without ready, then optionally the ready cycle.
    task automatic mem_phase(input int waits, input logic ld, input logic rw_exp,
                             input logic ready);
        dmem_ready = 1'b0;
        repeat (waits) begin
            #1;
            check("mem_wait_req", 32'(dmem_req), 32'd1);
            check("mem_wait_ren", 32'(mem_ren), 32'(ld));
            check("mem_wait_wen", 32'(mem_wen), 32'(!ld));
            check("mem_wait_reg_wen", 32'(reg_wen), 32'd0);
            check("mem_wait_pc_en", 32'(pc_en), 32'd0);
            check("mem_wait_wb_sel", 32'(wb_sel), 32'd0);
            tick();
        end
        if (ready) begin
            dmem_ready = 1'b1;
            #1;
            check("mem_done_req", 32'(dmem_req), 32'd1);
            check("mem_done_reg_wen", 32'(reg_wen), 32'(rw_exp));
            check("mem_done_wb_sel", 32'(wb_sel), ld ? 32'd1 : 32'd0);
            check("mem_done_pc_en", 32'(pc_en), 32'd1);
            tick();
            dmem_ready = 1'b0;
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_cause", 32'(trap_cause), 32'd0);
        check("rst_instret", 32'(instret), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        instr      = 32'd0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        tick();
        check("reset_imem_req", 32'(imem_req), 32'd0);
        check("reset_dmem_req", 32'(dmem_req), 32'd0);
        check("reset_reg_wen", 32'(reg_wen), 32'd0);
        check("reset_pc_en", 32'(pc_en), 32'd0);
        check("reset_alu_op", 32'(alu_op), 32'd0);
        check("reset_wb_sel", 32'(wb_sel), 32'd0);
        check("reset_trap", 32'(trap), 32'd0);
        check("reset_cause", 32'(trap_cause), 32'd0);
        check("reset_instret", 32'(instret), 32'd0);
        rst_n = 1'b1;

        // ADD x3,x1,x2 with ready on the first fetch cycle
        fetch(32'h002081B3, 0);
        exec_chk(3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        check("add_instret", 32'(instret), 32'd1);
        check("add_back_fetch", 32'(imem_req), 32'd1);

        // SUB x4,x1,x2 with two fetch wait cycles
        fetch(32'h40208233, 2);
        exec_chk(3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        check("sub_instret", 32'(instret), 32'd2);

        // LW x5,8(x1): ready on the 4th MEM cycle (the timeout boundary)
        fetch(32'h0080A283, 0);
        exec_chk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        mem_phase(3, 1'b1, 1'b1, 1'b1);
        check("lw_instret", 32'(instret), 32'd3);

        // SW x2,12(x1) with one wait, then JALR x1,0(x6)
        fetch(32'h0020A623, 1);
        exec_chk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        mem_phase(1, 1'b0, 1'b0, 1'b1);
        check("sw_instret", 32'(instret), 32'd4);
        fetch(32'h000300E7, 0);
        exec_chk(3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
        check("jalr_instret", 32'(instret), 32'd5);

        // ADDI x0,x0,5: rd = x0 suppresses the write but still retires
        fetch(32'h00500013, 0);
        exec_chk(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        check("addi_x0_instret", 32'(instret), 32'd6);

        // SRAI x1,x1,3 maps to SRL
        fetch(32'h4030D093, 0);
        exec_chk(3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        check("srai_instret", 32'(instret), 32'd7);

        // LW x0,8(x1): no register write even on completion
        fetch(32'h0080A003, 0);
        exec_chk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        mem_phase(0, 1'b1, 1'b0, 1'b1);
        check("lw_x0_instret", 32'(instret), 32'd8);

        // Illegal opcode 0x7F: trap, then 20 idle cycles with nothing moving
        fetch(32'h0000007F, 0);
        exec_chk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        check("illegal_trap", 32'(trap), 32'd1);
        check("illegal_cause", 32'(trap_cause), 32'd1);
        for (int i = 0; i < 20; i++) begin
            check("trap_imem_req", 32'(imem_req), 32'd0);
            check("trap_instret", 32'(instret), 32'd8);
            tick();
        end
        check("trap_cause_stable", 32'(trap_cause), 32'd1);
        reset_pulse();
        #1;
        check("post_trap_fetch", 32'(imem_req), 32'd1);

        // LW timeout: dmem_ready never arrives
        fetch(32'h0080A283, 0);
        exec_chk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        mem_phase(4, 1'b1, 1'b0, 1'b0);
        check("dmem_to_trap", 32'(trap), 32'd1);
        check("dmem_to_cause", 32'(trap_cause), 32'd3);
        check("dmem_to_req", 32'(dmem_req), 32'd0);
        check("dmem_to_instret", 32'(instret), 32'd0);
        reset_pulse();

        // Fetch timeout: imem_ready never arrives
        instr = 32'h002081B3;
        repeat (4) begin
            #1;
            check("imem_to_wait_req", 32'(imem_req), 32'd1);
            tick();
        end
        check("imem_to_trap", 32'(trap), 32'd1);
        check("imem_to_cause", 32'(trap_cause), 32'd2);
        check("imem_to_req", 32'(imem_req), 32'd0);
        reset_pulse();

        // LB (funct3 000) is not a supported load
        fetch(32'h00008283, 0);
        exec_chk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        check("lb_cause", 32'(trap_cause), 32'd1);
        reset_pulse();

        // Asynchronous reset in the middle of MEM drops the request at once
        fetch(32'h0080A283, 0);
        exec_chk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        #1;
        check("mid_mem_req", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_mem_rst_req", 32'(dmem_req), 32'd0);
        check("mid_mem_rst_ren", 32'(mem_ren), 32'd0);
        check("mid_mem_rst_instret", 32'(instret), 32'd0);
        rst_n = 1'b1;

        // 16 retirements wrap the 4-bit counter back to 0
        for (int i = 0; i < 16; i++) begin
            fetch(32'h00108093, 0);
            exec_chk(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
            check("instret_wrap", 32'(instret), 32'((i + 1) % 16));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
